// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch bus: memory request/ack toward imem, valid/ready toward decode, redirect from branch.
interface instr_fetch_if #(parameter int N = 64);
  import fetch_pkg::*;

  logic               imem_req;
  logic [N-1:0]       imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [N-1:0]       pc_out;
  logic               redirect;
  logic [N-1:0]       redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc_out,
    input  imem_ack, imem_data, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc_out,
    output imem_ack, imem_data, instr_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/instr_fetch_pc_reg.sv
// Word-aligned address register with synchronous reset and load enable.
module pc_reg #(
  parameter int             N        = 64,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  localparam logic [N-1:0] RST_VAL = RESET_PC & ~N'(3);

  always_ff @(posedge clk) begin
    if (reset)     q <= RST_VAL;
    else if (load) q <= d;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, talks to variable-latency imem and hands words to decode.
// States: S_FETCH request at pc | S_VALID word held for decode | S_DROP wait out a wrong-path ack
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int           N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  state_t             state;
  logic               req_q;
  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [N-1:0]       pc_out_q;
  logic [N-1:0]       pc;
  logic [N-1:0]       pc_d;
  logic               pc_load;
  logic [N-1:0]       hold_addr;
  logic               hold_load;

  // Redirect beats everything except reset, which pc_reg handles internally.
  always_comb begin
    pc_load = 1'b0;
    pc_d    = pc + N'(PC_INC);
    if (bus.redirect) begin
      pc_load = 1'b1;
      pc_d    = bus.redirect_pc & ~N'(3);
    end else if (state == S_FETCH && bus.imem_ack) begin
      pc_load = 1'b1;
    end
  end

  // Tracks pc while fetching so S_DROP can keep presenting the abandoned address.
  assign hold_load = (state == S_FETCH);

  pc_reg #(.N(N), .RESET_PC(RESET_PC)) u_pc (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .d     (pc_d),
    .q     (pc)
  );

  pc_reg #(.N(N), .RESET_PC(RESET_PC)) u_hold (
    .clk   (clk),
    .reset (reset),
    .load  (hold_load),
    .d     (pc),
    .q     (hold_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      req_q    <= 1'b1;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.redirect && !bus.imem_ack) begin
            state <= S_DROP;
          end else if (bus.imem_ack && !bus.redirect) begin
            state    <= S_VALID;
            req_q    <= 1'b0;
            valid_q  <= 1'b1;
            instr_q  <= bus.imem_data;
            pc_out_q <= pc;
          end
        end
        S_VALID: begin
          if (bus.redirect || bus.instr_ready) begin
            state   <= S_FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        S_DROP: begin
          if (bus.imem_ack) state <= S_FETCH;
        end
        default: begin
          state   <= S_FETCH;
          req_q   <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Request and valid are forced low for the whole time reset is asserted.
  assign bus.imem_req    = req_q & ~reset;
  assign bus.instr_valid = valid_q & ~reset;
  assign bus.instr       = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.imem_addr   = (state == S_DROP) ? hold_addr : pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a scoreboard of instructions expected at decode.
module tb_instr_fetch;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  instr_fetch_if #(.N(64)) f0 ();
  instr_fetch_if #(.N(64)) f1 ();

  instr_fetch #(.N(64), .RESET_PC(64'h0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (f0)
  );

  instr_fetch #(.N(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (f1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] i, input logic [63:0] p);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    sb.push_back(e);
  endtask

  // Whatever decode sees while valid must be the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && f0.instr_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: got instr %h pc %h expected no valid", f0.instr, f0.pc_out);
      end else begin
        chk("sb_instr", {32'h0, f0.instr}, {32'h0, sb[0].instr});
        chk("sb_pc", f0.pc_out, sb[0].pc);
        if (f0.instr_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    f0.imem_ack = 1'b0; f0.imem_data = '0; f0.instr_ready = 1'b0;
    f0.redirect = 1'b0; f0.redirect_pc = '0;
    f1.imem_ack = 1'b0; f1.imem_data = '0; f1.instr_ready = 1'b1;
    f1.redirect = 1'b0; f1.redirect_pc = '0;

    step(); step();
    chk("rst_req", {63'h0, f0.imem_req}, 64'h0);
    chk("rst_valid", {63'h0, f0.instr_valid}, 64'h0);
    chk("rst_pc_out", f0.pc_out, 64'h0);
    chk("rst_instr", {32'h0, f0.instr}, 64'h0);
    reset = 1'b0;
    #1;
    chk("rel_req", {63'h0, f0.imem_req}, 64'h1);
    chk("rel_addr", f0.imem_addr, 64'h0);

    // zero-wait fetch at 0
    f0.imem_ack = 1'b1; f0.imem_data = 32'h8B02_0020; f0.instr_ready = 1'b1;
    push(32'h8B02_0020, 64'h0);
    step();
    f0.imem_ack = 1'b0;
    chk("zw_valid", {63'h0, f0.instr_valid}, 64'h1);
    chk("zw_req", {63'h0, f0.imem_req}, 64'h0);
    step();
    chk("zw_next_req", {63'h0, f0.imem_req}, 64'h1);
    chk("zw_next_addr", f0.imem_addr, 64'h4);
    chk("zw_next_valid", {63'h0, f0.instr_valid}, 64'h0);

    // backpressure at 4
    f0.imem_ack = 1'b1; f0.imem_data = 32'hF840_0000; f0.instr_ready = 1'b0;
    push(32'hF840_0000, 64'h4);
    step();
    f0.imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {63'h0, f0.instr_valid}, 64'h1);
      chk("bp_instr", {32'h0, f0.instr}, 64'hF840_0000);
      chk("bp_pc_out", f0.pc_out, 64'h4);
      chk("bp_req", {63'h0, f0.imem_req}, 64'h0);
      step();
    end
    f0.instr_ready = 1'b1;
    step();
    chk("bp_rel_valid", {63'h0, f0.instr_valid}, 64'h0);
    chk("bp_rel_req", {63'h0, f0.imem_req}, 64'h1);
    chk("bp_rel_addr", f0.imem_addr, 64'h8);

    // redirect while request to 8 is outstanding; ack arrives three cycles later
    f0.redirect = 1'b1; f0.redirect_pc = 64'h40;
    step();
    f0.redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drop_addr", f0.imem_addr, 64'h8);
      chk("drop_req", {63'h0, f0.imem_req}, 64'h1);
      if (i == 2) begin
        f0.imem_ack = 1'b1; f0.imem_data = 32'hDEAD_BEEF;
      end
      step();
    end
    f0.imem_ack = 1'b0;
    chk("drop_done_addr", f0.imem_addr, 64'h40);
    chk("drop_done_req", {63'h0, f0.imem_req}, 64'h1);
    chk("drop_done_valid", {63'h0, f0.instr_valid}, 64'h0);

    // redirect together with the decode handshake
    f0.imem_ack = 1'b1; f0.imem_data = 32'h9100_0421; f0.instr_ready = 1'b0;
    push(32'h9100_0421, 64'h40);
    step();
    f0.imem_ack = 1'b0;
    f0.instr_ready = 1'b1; f0.redirect = 1'b1; f0.redirect_pc = 64'h103;
    step();
    f0.redirect = 1'b0; f0.instr_ready = 1'b0;
    chk("hs_redir_valid", {63'h0, f0.instr_valid}, 64'h0);
    chk("hs_redir_addr", f0.imem_addr, 64'h100);

    // redirect kills a held instruction that decode never accepted
    f0.imem_ack = 1'b1; f0.imem_data = 32'hAAAA_0001;
    push(32'hAAAA_0001, 64'h100);
    step();
    f0.imem_ack = 1'b0;
    f0.redirect = 1'b1; f0.redirect_pc = 64'h200;
    step();
    f0.redirect = 1'b0;
    void'(sb.pop_front());
    chk("kill_valid", {63'h0, f0.instr_valid}, 64'h0);
    chk("kill_addr", f0.imem_addr, 64'h200);

    // redirect in the same cycle as an ack: data dropped, refetch at target
    f0.imem_ack = 1'b1; f0.imem_data = 32'hBBBB_0002;
    f0.redirect = 1'b1; f0.redirect_pc = 64'h300;
    step();
    f0.imem_ack = 1'b0; f0.redirect = 1'b0;
    chk("ackredir_valid", {63'h0, f0.instr_valid}, 64'h0);
    chk("ackredir_req", {63'h0, f0.imem_req}, 64'h1);
    chk("ackredir_addr", f0.imem_addr, 64'h300);

    f0.imem_ack = 1'b1; f0.imem_data = 32'hCAFE_0003; f0.instr_ready = 1'b1;
    push(32'hCAFE_0003, 64'h300);
    step();
    f0.imem_ack = 1'b0;
    chk("last_valid", {63'h0, f0.instr_valid}, 64'h1);
    step();
    chk("last_addr", f0.imem_addr, 64'h304);

    // PC wrap on the second instance
    chk("wrap_addr0", f1.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    f1.imem_ack = 1'b1; f1.imem_data = 32'h1400_0001;
    step();
    f1.imem_ack = 1'b0;
    chk("wrap_valid", {63'h0, f1.instr_valid}, 64'h1);
    chk("wrap_pc_out", f1.pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_instr", {32'h0, f1.instr}, 64'h1400_0001);
    step();
    chk("wrap_next_addr", f1.imem_addr, 64'h0);
    chk("wrap_next_req", {63'h0, f1.imem_req}, 64'h1);

    step();
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
